// File: rtl/i2c_target_pkg.sv
// Shared constants and state encoding for the I2C target.
//   state_e        : byte-level protocol states
//   DevAddrDefault : default 7-bit target address
//   FiltDefault    : default glitch-filter length in clk cycles
//   BitsPerByte    : bit-counter value after the last data bit of a byte
package i2c_target_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAack,
    StSub,
    StSack,
    StWdata,
    StWack,
    StRdata,
    StRack,
    StWait
  } state_e;

  localparam logic [6:0]  DevAddrDefault = 7'h48;
  localparam int unsigned FiltDefault    = 4;
  localparam logic [3:0]  BitsPerByte    = 4'd8;

endpackage

// File: rtl/i2c_filt.sv
// Input conditioner for one asynchronous bus line.
// Two-flop synchroniser followed by a stability filter: the filtered value only
// follows the synchronised input once the two have differed for FILT consecutive
// clk cycles. rise_o/fall_o pulse for one cycle, in the first cycle filt_o shows
// the new level.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset (line assumed idle high)
//   in_i    : raw asynchronous input
//   filt_o  : filtered level
//   rise_o  : one-cycle pulse on filtered 0->1
//   fall_o  : one-cycle pulse on filtered 1->0
module i2c_filt #(
  parameter int unsigned FILT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (FILT > 1) ? $clog2(FILT) : 1;

  logic            sync1_q, sync2_q;
  logic            filt_q, rise_q, fall_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (sync2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FILT - 1)) begin
        // Input has differed for FILT cycles in a row: accept it.
        filt_q <= sync2_q;
        rise_q <= sync2_q;
        fall_q <= ~sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-bit subaddressed register-file port. Oversamples scl/sda
// with clk, never stretches the clock.
//   clk        : system clock
//   rstn       : asynchronous active-low reset
//   scl        : raw bus clock
//   sdain      : raw bus data (IOBUF O)
//   sdaout     : IOBUF T (0 = pull sda low, 1 = release); IOBUF I is tied 0
//   regaddr    : register address pointer
//   regwrdata  : write data, valid while regwr=1
//   regwr      : one-cycle write strobe
//   regrd      : one-cycle read request for regaddr
//   regrddata  : read data, sampled one clk after regrd
//   busy       : high between START and STOP
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  DEVADDR = DevAddrDefault,
  parameter int unsigned FILT    = FiltDefault
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scl,
  input  logic       sdain,
  output logic       sdaout,
  output logic [7:0] regaddr,
  output logic [7:0] regwrdata,
  output logic       regwr,
  output logic       regrd,
  input  logic [7:0] regrddata,
  output logic       busy
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_filt #(.FILT(FILT)) u_scl_filt (
    .clk_i  (clk),
    .rst_ni (rstn),
    .in_i   (scl),
    .filt_o (scl_f),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_filt #(.FILT(FILT)) u_sda_filt (
    .clk_i  (clk),
    .rst_ni (rstn),
    .in_i   (sdain),
    .filt_o (sda_f),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  // scl_f already shows the post-edge level, so an sda edge landing on the same
  // cycle as an scl fall is not mistaken for START/STOP.
  logic start_det, stop_det;
  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;

  state_e     state_q;
  logic [3:0] bitcnt_q;
  logic [7:0] shift_q;
  logic       rw_q;
  logic       ack_q;
  logic       sdaout_q, busy_q, regwr_q, regrd_q;
  logic [7:0] regaddr_q, regwrdata_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      sdaout_q    <= 1'b1;
      busy_q      <= 1'b0;
      regwr_q     <= 1'b0;
      regrd_q     <= 1'b0;
      regaddr_q   <= '0;
      regwrdata_q <= '0;
    end else begin
      regwr_q <= 1'b0;
      regrd_q <= 1'b0;

      // Pointer advances the cycle after a write strobe.
      if (regwr_q) begin
        regaddr_q <= regaddr_q + 8'd1;
      end
      // Read data arrives one clk after the request; present its MSB at once.
      if (regrd_q) begin
        shift_q  <= regrddata;
        sdaout_q <= regrddata[7];
      end

      if (start_det) begin
        state_q  <= StAddr;
        busy_q   <= 1'b1;
        bitcnt_q <= '0;
        sdaout_q <= 1'b1;
      end else if (stop_det) begin
        state_q  <= StIdle;
        busy_q   <= 1'b0;
        bitcnt_q <= '0;
        sdaout_q <= 1'b1;
      end else begin
        unique case (state_q)
          StAddr, StSub, StWdata: begin
            if (scl_rise) begin
              shift_q  <= {shift_q[6:0], sda_f};
              bitcnt_q <= bitcnt_q + 4'd1;
              if (state_q == StWdata && bitcnt_q == BitsPerByte - 4'd1) begin
                regwrdata_q <= {shift_q[6:0], sda_f};
                regwr_q     <= 1'b1;
              end
            end else if (scl_fall && bitcnt_q == BitsPerByte) begin
              bitcnt_q <= '0;
              if (state_q == StAddr) begin
                if (shift_q[7:1] == DEVADDR) begin
                  rw_q     <= shift_q[0];
                  sdaout_q <= 1'b0;
                  state_q  <= StAack;
                end else begin
                  state_q <= StWait;
                end
              end else if (state_q == StSub) begin
                regaddr_q <= shift_q;
                sdaout_q  <= 1'b0;
                state_q   <= StSack;
              end else begin
                sdaout_q <= 1'b0;
                state_q  <= StWack;
              end
            end
          end
          StAack: begin
            if (scl_fall) begin
              sdaout_q <= 1'b1;
              bitcnt_q <= '0;
              if (rw_q) begin
                regrd_q <= 1'b1;
                state_q <= StRdata;
              end else begin
                state_q <= StSub;
              end
            end
          end
          StSack, StWack: begin
            if (scl_fall) begin
              sdaout_q <= 1'b1;
              bitcnt_q <= '0;
              state_q  <= StWdata;
            end
          end
          StRdata: begin
            if (scl_rise) begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt_q == BitsPerByte) begin
                sdaout_q <= 1'b1;
                bitcnt_q <= '0;
                ack_q    <= 1'b0;
                state_q  <= StRack;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sdaout_q <= shift_q[6];
              end
            end
          end
          StRack: begin
            if (scl_rise) begin
              if (!sda_f) begin
                ack_q     <= 1'b1;
                regaddr_q <= regaddr_q + 8'd1;
              end else begin
                state_q <= StWait;
              end
            end else if (scl_fall && ack_q) begin
              // Next byte is only driven after scl is low again.
              regrd_q  <= 1'b1;
              bitcnt_q <= '0;
              state_q  <= StRdata;
            end
          end
          default: begin
            // StIdle, StWait: bus released, waiting for START/STOP.
          end
        endcase
      end
    end
  end

  assign sdaout    = sdaout_q;
  assign busy      = busy_q;
  assign regwr     = regwr_q;
  assign regrd     = regrd_q;
  assign regaddr   = regaddr_q;
  assign regwrdata = regwrdata_q;

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;

  localparam logic [6:0] Dev = 7'h48;
  localparam int         HP  = 20;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] regrddata;
  logic       sdaout, busy, regwr, regrd;
  logic [7:0] regaddr, regwrdata;
  logic       bus_sda;

  assign bus_sda = sda_m & sdaout;

  i2c_target #(.DEVADDR(Dev), .FILT(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .scl       (scl_m),
    .sdain     (bus_sda),
    .sdaout    (sdaout),
    .regaddr   (regaddr),
    .regwrdata (regwrdata),
    .regwr     (regwr),
    .regrd     (regrd),
    .regrddata (regrddata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents and the expected pointer.
  logic [7:0] mem[256];
  logic [7:0] ptr;

  int         exp_wr_q[$];
  int         exp_rd_q[$];
  int         exp_bus_q[$];
  int         obs_bus_q[$];
  logic [7:0] wdata_q[$];

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  // Monitor and register-file responder.
  always @(negedge clk) begin
    if (rstn) begin
      if (regwr || regrd) check("strobe exclusive", int'(regwr & regrd), 0);
      if (regwr) begin
        if (exp_wr_q.size() == 0) check("unexpected regwr", int'({regaddr, regwrdata}), -1);
        else check("regwr addr/data", int'({regaddr, regwrdata}), exp_wr_q.pop_front());
      end
      if (regrd) begin
        if (exp_rd_q.size() == 0) check("unexpected regrd", int'(regaddr), -1);
        else check("regrd addr", int'(regaddr), exp_rd_q.pop_front());
        regrddata = mem[regaddr];
      end
      while (obs_bus_q.size() > 0) begin
        if (exp_bus_q.size() == 0) check("extra bus item", obs_bus_q.pop_front(), -1);
        else check("bus ack/byte", obs_bus_q.pop_front(), exp_bus_q.pop_front());
      end
    end
  end

  initial begin
    #1500us;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic hp();
    repeat (HP) @(posedge clk);
    #2;
  endtask

  task automatic settle();
    repeat (5) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    hp();
    scl_m = 1'b1;
    hp();
    scl_m = 1'b0;
    settle();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1;
    hp();
    scl_m = 1'b1;
    repeat (HP / 2) @(posedge clk);
    #2;
    b = bus_sda;
    repeat (HP / 2) @(posedge clk);
    #2;
    scl_m = 1'b0;
    settle();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    hp();
    scl_m = 1'b1;
    hp();
    sda_m = 1'b0;
    hp();
    scl_m = 1'b0;
    settle();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    hp();
    scl_m = 1'b1;
    hp();
    sda_m = 1'b1;
    hp();
  endtask

  task automatic send_byte(input logic [7:0] b, input int exp_ack);
    logic ack;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    exp_bus_q.push_back(exp_ack);
    recv_bit(ack);
    obs_bus_q.push_back(int'(ack));
  endtask

  task automatic end_checks();
    settle();
    check("busy after STOP", int'(busy), 0);
    check("sdaout after STOP", int'(sdaout), 1);
    check("regaddr after STOP", int'(regaddr), int'(ptr));
  endtask

  // Write transaction: address byte, subaddress, then wdata_q.
  task automatic do_write(input logic [6:0] a, input logic [7:0] sub);
    int nak;
    nak = (a == Dev) ? 0 : 1;
    i2c_start();
    check("busy after START", int'(busy), 1);
    send_byte({a, 1'b0}, nak);
    send_byte(sub, nak);
    if (nak == 0) ptr = sub;
    foreach (wdata_q[i]) begin
      if (nak == 0) begin
        exp_wr_q.push_back(int'({ptr, wdata_q[i]}));
        mem[ptr] = wdata_q[i];
        ptr = ptr + 8'd1;
      end
      send_byte(wdata_q[i], nak);
    end
    i2c_stop();
    end_checks();
  endtask

  // Read n bytes, optionally setting the subaddress first via repeated START.
  task automatic do_read(input logic use_sub, input logic [7:0] sub, input int n);
    logic [7:0] b;
    logic       last;
    i2c_start();
    check("busy after START", int'(busy), 1);
    if (use_sub) begin
      send_byte({Dev, 1'b0}, 0);
      send_byte(sub, 0);
      ptr = sub;
      i2c_start();
    end
    exp_rd_q.push_back(int'(ptr));
    send_byte({Dev, 1'b1}, 0);
    for (int k = 0; k < n; k++) begin
      exp_bus_q.push_back(int'(mem[ptr]));
      b = '0;
      for (int i = 7; i >= 0; i--) recv_bit(b[i]);
      obs_bus_q.push_back(int'(b));
      last = (k == n - 1);
      if (!last) begin
        ptr = ptr + 8'd1;
        exp_rd_q.push_back(int'(ptr));
      end
      send_bit(last);
    end
    i2c_stop();
    end_checks();
  endtask

  initial begin
    int w;
    int kind;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    ptr = 8'h00;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("reset sdaout", int'(sdaout), 1);
    check("reset regaddr", int'(regaddr), 0);
    check("reset regwrdata", int'(regwrdata), 0);
    check("reset regwr", int'(regwr), 0);
    check("reset regrd", int'(regrd), 0);
    check("reset busy", int'(busy), 0);
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    #2;

    // 2-clk sda glitch while scl high must not look like START.
    sda_m = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    sda_m = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    check("glitch busy", int'(busy), 0);

    // Directed write, read, mismatch, wrap.
    wdata_q = '{8'hAA, 8'h55};
    do_write(Dev, 8'h10);
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'hC3;
    do_read(1'b1, 8'h20, 2);
    wdata_q.delete();
    do_write(7'h49, 8'h01);
    wdata_q = '{8'h11, 8'h22};
    do_write(Dev, 8'hFF);

    // Abort: STOP after 4 data bits.
    i2c_start();
    send_byte({Dev, 1'b0}, 0);
    send_byte(8'h30, 0);
    ptr = 8'h30;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    i2c_stop();
    end_checks();
    wdata_q = '{8'h5A};
    do_write(Dev, 8'h40);

    // Randomised transactions.
    for (int it = 0; it < 8; it++) begin
      kind = int'($urandom_range(0, 3));
      wdata_q.delete();
      if (kind == 0) begin
        repeat ($urandom_range(1, 3)) wdata_q.push_back(8'($urandom));
        do_write(Dev, 8'($urandom));
      end else if (kind == 1) begin
        do_read(1'b1, 8'($urandom), int'($urandom_range(1, 3)));
      end else if (kind == 2) begin
        do_read(1'b0, 8'h00, int'($urandom_range(1, 2)));
      end else begin
        wdata_q.push_back(8'($urandom));
        do_write(Dev ^ (7'd1 << $urandom_range(0, 6)), 8'($urandom));
      end
    end

    // Reset asserted while the address ACK is being driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : Dev[i-1]);
    w = 0;
    while (sdaout !== 1'b0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #3;
    check("address ack driven", int'(sdaout), 0);
    rstn = 1'b0;
    #1;
    check("rst sdaout", int'(sdaout), 1);
    check("rst busy", int'(busy), 0);
    check("rst regaddr", int'(regaddr), 0);
    check("rst regwr/regrd", int'({regwr, regrd}), 0);
    ptr = 8'h00;
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    rstn = 1'b1;
    hp();
    wdata_q = '{8'h77};
    do_write(Dev, 8'h05);

    repeat (20) @(posedge clk);
    #2;
    check("leftover regwr", exp_wr_q.size(), 0);
    check("leftover regrd", exp_rd_q.size(), 0);
    check("leftover bus", exp_bus_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
